// File: rtl/rv_fetch_pkg.sv
// Shared types for the RV32I fetch stage.
// Fetch-queue entry layout and PC helpers.
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  import rv_fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush.
// Head is read straight from storage registers.
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign full   = count == CW'(DEPTH);
  assign empty  = count == '0;
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, fetch queue.
// Define FETCH_BYPASS_EN to forward a response to decode in the same cycle.
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic            run;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [CW:0]     in_use;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  fetch_entry_t    q_din;
  fetch_entry_t    q_dout;
  logic            accept;
  logic            rsp_keep;
  logic            hshake;

  // Every accepted request owns a queue slot until it is consumed.
  assign in_use = {1'b0, outstanding} + {1'b0, q_count};

  assign imem.imem_req_valid = run && !redirect_valid
                             && (in_use < (CW+1)'(FQ_DEPTH));
  assign imem.imem_req_addr  = fetch_pc;

  assign accept   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_keep = imem.imem_rsp_valid && (drop_cnt == '0)
                  && !redirect_valid;
  assign q_din    = '{instr: imem.imem_rsp_data, pc: rsp_pc};
  assign hshake   = instr_valid && instr_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  assign bypass      = rsp_keep && q_empty;
  assign instr_valid = !q_empty || bypass;
  assign instr       = bypass ? imem.imem_rsp_data : q_dout.instr;
  assign instr_pc    = bypass ? rsp_pc : q_dout.pc;
  assign q_push      = rsp_keep && !(bypass && instr_ready)
                     && (!q_full || q_pop);
  assign q_pop       = hshake && !bypass;
`else
  assign instr_valid = !q_empty;
  assign instr       = q_dout.instr;
  assign instr_pc    = q_dout.pc;
  assign q_push      = rsp_keep && (!q_full || q_pop);
  assign q_pop       = hshake;
`endif

  assign instr_pc_plus4 = instr_pc + 32'd4;

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding + CW'(accept)
                   - CW'(imem.imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        // Responses still in flight after this edge belong to the old path.
        drop_cnt <= outstanding - CW'(imem.imem_rsp_valid);
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 32'd4;
        end else if (imem.imem_rsp_valid) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

endmodule
